// File: rtl/fb_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative RV32M multiply/divide unit.
// The execute stage drives the request side; the unit drives busy/done/result.
interface fb_muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [7:0]      md_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, md_op, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, md_op, op_a, op_b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/fb_muldiv.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add multiply or restoring divide on operand
// magnitudes, followed by sign fix-up; divide-by-zero and signed overflow resolve in one cycle.
module fb_muldiv #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    fb_muldiv_if.slave md
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO_W   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (ZERO_W - v) : v;
    endfunction

    state_t              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [XLEN-1:0]     a_mag_q, a_mag_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                neg_pq_q, neg_pq_d;
    logic                neg_r_q, neg_r_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                sign_a_s, sign_b_s, a_neg_s, b_neg_s;
    logic                is_div_in_s, div_zero_s, div_ovf_s;
    logic [XLEN-1:0]     fast_val_s;
    logic                op_is_div_s;
    logic [XLEN:0]       rem_shift_s, rem_diff_s;
    logic [2*XLEN-1:0]   product_s;

    // Operand classification for an incoming request (only used when a start is accepted).
    always_comb begin
        sign_a_s    = md.md_op[7] | md.md_op[6] | md.md_op[5] | md.md_op[3] | md.md_op[1];
        sign_b_s    = md.md_op[7] | md.md_op[6] | md.md_op[3] | md.md_op[1];
        a_neg_s     = sign_a_s & md.op_a[XLEN-1];
        b_neg_s     = sign_b_s & md.op_b[XLEN-1];
        is_div_in_s = |md.md_op[3:0];
        div_zero_s  = is_div_in_s && (md.op_b == ZERO_W);
        div_ovf_s   = (md.md_op[3] | md.md_op[1]) && (md.op_a == MIN_NEG) && (md.op_b == ALL_ONES);
        if (div_zero_s) begin
            fast_val_s = (md.md_op[3] | md.md_op[2]) ? ALL_ONES : md.op_a;
        end else begin
            fast_val_s = md.md_op[3] ? MIN_NEG : ZERO_W;
        end
    end

    // One restoring-division step and the sign-corrected product for the fix-up cycle.
    always_comb begin
        op_is_div_s = |op_q[3:0];
        rem_shift_s = {acc_q[XLEN-1:0], a_mag_q[XLEN-1]};
        rem_diff_s  = rem_shift_s - {1'b0, b_mag_q};
        product_s   = neg_pq_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
    end

    // Next-state and datapath update; flush overrides everything and leaves result untouched.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_pq_d = neg_pq_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        if (md.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = 5'd0;
                    acc_d = {(2*XLEN){1'b0}};
                    if (md.start && is_onehot8(md.md_op)) begin
                        op_d     = md.md_op;
                        a_mag_d  = cond_neg(md.op_a, a_neg_s);
                        b_mag_d  = cond_neg(md.op_b, b_neg_s);
                        neg_pq_d = a_neg_s ^ b_neg_s;
                        neg_r_d  = a_neg_s;
                        if (div_zero_s || div_ovf_s) begin
                            result_d = fast_val_s;
                            state_d  = S_DONE;
                        end else begin
                            state_d  = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q + 5'd1;
                    if (op_is_div_s) begin
                        // Quotient bits shift into the dividend register as its bits are consumed.
                        acc_d[XLEN-1:0] = rem_diff_s[XLEN] ? rem_shift_s[XLEN-1:0] : rem_diff_s[XLEN-1:0];
                        a_mag_d         = {a_mag_q[XLEN-2:0], ~rem_diff_s[XLEN]};
                    end else begin
                        acc_d   = {acc_q[2*XLEN-2:0], 1'b0} + (b_mag_q[XLEN-1] ? {ZERO_W, a_mag_q} : {(2*XLEN){1'b0}});
                        b_mag_d = {b_mag_q[XLEN-2:0], 1'b0};
                    end
                    if (cnt_q == 5'd31) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    case (op_q)
                        8'h80:   result_d = product_s[XLEN-1:0];
                        8'h40,
                        8'h20,
                        8'h10:   result_d = product_s[2*XLEN-1:XLEN];
                        8'h08,
                        8'h04:   result_d = cond_neg(a_mag_q, neg_pq_q);
                        8'h02,
                        8'h01:   result_d = cond_neg(acc_q[XLEN-1:0], neg_r_q);
                        default: result_d = result_q;
                    endcase
                    state_d = S_DONE;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= 8'h00;
            a_mag_q  <= ZERO_W;
            b_mag_q  <= ZERO_W;
            acc_q    <= {(2*XLEN){1'b0}};
            cnt_q    <= 5'd0;
            neg_pq_q <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= ZERO_W;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_pq_q <= neg_pq_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
        end
    end

    assign md.busy   = (state_q != S_IDLE);
    assign md.done   = (state_q == S_DONE);
    assign md.result = result_q;
endmodule

// File: tb/tb_fb_muldiv.sv
// Directed bench for fb_muldiv: expected results queued at request time, popped and compared on done.
module tb_fb_muldiv;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fb_muldiv_if bus ();
    fb_muldiv dut (.clk(clk), .rst_n(rst_n), .md(bus));

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done pops one expected result.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_done", {63'd0, bus.done}, 64'd0);
            end else begin
                check("result", {32'd0, bus.result}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_op(input string name, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat_exp, input int pulse_at);
        int lat;
        int bcnt;
        int d0;
        bit seen;
        lat = 0; bcnt = 0; seen = 1'b0;
        @(negedge clk);
        d0 = done_cnt;
        bus.start = 1'b1; bus.md_op = op; bus.op_a = a; bus.op_b = b;
        exp_q.push_back(exp);
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) bcnt++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
            bus.start = (i == pulse_at);
            bus.md_op = (i == pulse_at) ? 8'h08 : 8'h00;
            bus.op_a  = $urandom;
            bus.op_b  = $urandom;
        end
        check({name, "_latency"}, lat, lat_exp);
        check({name, "_busy_cycles"}, bcnt, lat_exp);
        @(negedge clk);
        check({name, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
        repeat (2) @(negedge clk);
        check({name, "_result_hold"}, {32'd0, bus.result}, {32'd0, exp});
        check({name, "_done_count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        bus.start = 1'b0; bus.md_op = 8'h00; bus.op_a = 32'd0; bus.op_b = 32'd0; bus.flush = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_result", {32'd0, bus.result}, 64'd0);
        rst_n = 1'b1;

        do_op("mul",    8'h80, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        do_op("mulh",   8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
        do_op("mulhsu", 8'h20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
        do_op("mulhu",  8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 34, 0);
        do_op("div",    8'h08, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, 0);
        do_op("rem",    8'h02, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, 0);
        do_op("divu",   8'h04, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34, 0);
        do_op("remu",   8'h01, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 34, 0);
        do_op("div_z",  8'h08, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0);
        do_op("remu_z", 8'h01, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1, 0);
        do_op("div_ov", 8'h08, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        do_op("rem_ov", 8'h02, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
        do_op("mul_sp", 8'h80, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 34, 5);

        // Malformed opcodes are ignored.
        @(negedge clk); bus.start = 1'b1; bus.md_op = 8'h00; bus.op_a = 32'd9; bus.op_b = 32'd3;
        @(negedge clk); bus.start = 1'b0;
        check("ign_00_busy", {63'd0, bus.busy}, 64'd0);
        bus.start = 1'b1; bus.md_op = 8'h81;
        @(negedge clk); bus.start = 1'b0; bus.md_op = 8'h00;
        check("ign_81_busy", {63'd0, bus.busy}, 64'd0);

        // Flush in the middle of CALC.
        @(negedge clk); bus.start = 1'b1; bus.md_op = 8'h80; bus.op_a = 32'd3; bus.op_b = 32'd5;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.md_op = 8'h00;
            if (i == 10) bus.flush = 1'b1;
        end
        @(negedge clk); bus.flush = 1'b0;
        check("flush_busy", {63'd0, bus.busy}, 64'd0);
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("flush_no_done", done_cnt, d0);
        check("flush_result", {32'd0, bus.result}, 64'h2A);
        do_op("post_flush", 8'h80, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 34, 0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk); bus.start = 1'b1; bus.md_op = 8'h04; bus.op_a = 32'd100; bus.op_b = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.md_op = 8'h00;
        end
        rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_result", {32'd0, bus.result}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        d0 = done_cnt;
        repeat (40) @(negedge clk);
        check("arst_no_done", done_cnt, d0);
        do_op("post_rst", 8'h04, 32'd100, 32'd7, 32'd14, 34, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fb_muldiv.md
# fb_muldiv

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ALU control decoder. Consumes the eight RV32M one-hot control bits (bits 18..11 of the 19-bit ALU control word: mul, mulh, mulhsu, mulhu, div, divu, rem, remu) together with both source operands. Computes the result over multiple cycles and holds the pipeline via `busy` until the result is delivered.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe from execute; sampled only in IDLE.
- `md_op`  in  8  {mul, mulh, mulhsu, mulhu, div, divu, rem, remu}, one-hot, MSB = mul.
- `op_a`  in  XLEN  rs1 value (multiplicand / dividend).
- `op_b`  in  XLEN  rs2 value (multiplier / divisor).
- `flush`  in  1  synchronous kill from pipeline control.
- `busy`  out  1  high in every state except IDLE; drives execute stall.
- `done`  out  1  one-cycle pulse; `result` valid while high.
- `result`  out  XLEN  registered result; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on `start`=1 with exactly one `md_op` bit set, latch op, signedness and operand magnitudes. Signed operands are mul/mulh/div/rem (both operands) and mulhsu (`op_a` only). Clear the 64-bit accumulator and the 5-bit counter, then go to CALC. `start` with zero or multiple `md_op` bits: ignored, stay in IDLE.
- Fast path, evaluated in IDLE on an accepted start; writes `result` and goes straight to DONE:
  - divisor zero, div/divu: `result` = 0xFFFFFFFF.
  - divisor zero, rem/remu: `result` = `op_a`.
  - signed overflow (`op_a`=0x80000000, `op_b`=0xFFFFFFFF), div: `result` = 0x80000000.
  - signed overflow, rem: `result` = 0.
- CALC, multiply: radix-2 shift-add on magnitudes, one multiplier bit per cycle, 64-bit unsigned product.
- CALC, divide: restoring division, one quotient bit per cycle, producing a 32-bit quotient and a 32-bit remainder.
- CALC runs exactly 32 cycles; leaves to FIX when the counter wraps from 31.
- FIX, sign correction:
  - product negated (two's complement, 64-bit) if the operand signs differ under the active signedness.
  - quotient negated if the dividend and divisor signs differ.
  - remainder takes the sign of the dividend.
- FIX, selection:
  - mul: product[31:0].
  - mulh/mulhsu/mulhu: product[63:32].
  - div/divu: quotient.
  - rem/remu: remainder.
  - `result` is written, then go to DONE.
- DONE: `done`=1 for exactly this cycle, then IDLE.
- `flush`=1 in any state: next state IDLE; `done` is not generated and `result` keeps its previous value. `flush` has priority over `start` in the same cycle.
- `start` while not in IDLE is ignored and not queued. Operand inputs may change freely after acceptance.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, `busy`=0, `done`=0, `result`=0, counter 0, accumulator 0. Reset asserted mid-operation aborts immediately with no `done`.
- Normal latency: `start` accepted at edge E0 → `busy` high from E0 → CALC covers E1..E32 → FIX writes `result` at E33 → `done`=1 in the cycle after E33 → IDLE at E34. Total 34 cycles of `busy`.
- Fast path: `result` written at E0, `done`=1 in the cycle after E0, IDLE at E1. `busy` is high for 1 cycle.
- `done` and `busy` are both high in the DONE cycle; `busy` falls together with `done`.
- Back-to-back: a new `start` is accepted on the edge leaving DONE only if the pipeline re-presents it in IDLE. The earliest next acceptance is the cycle after `done`.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.

## Test plan
- mul 0x00000007 × 0xFFFFFFFD (−3) → `result`=0xFFFFFFEB, `done` 34 cycles after start, `busy` high 34 cycles.
- mulh, mulhsu, mulhu with `op_a`=0x80000000, `op_b`=0xFFFFFFFF → 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF; divu 0xFFFFFFF9/2 → 0x7FFFFFFC; remu 0xFFFFFFF9/2 → 1.
- Fast-path cases, each with `done` one cycle after start:
  - div 5/0 → 0xFFFFFFFF; remu 5/0 → 5.
  - div 0x80000000/−1 → 0x80000000; rem 0x80000000/−1 → 0.
- `flush` at CALC cycle 10 → `busy` low next cycle, no `done`, `result` unchanged. A new start immediately afterwards completes normally. Repeat the abort using `rst_n` mid-CALC.
- `start` with `md_op`=0x00 or 0x81 → ignored, `busy` stays 0. `start` pulsed during CALC → ignored, exactly one `done`.
